rx_frame_buf: RTL and testbench

- Receive-side framing stage, directly upstream of the bus receive controller.
- Takes the PHY byte stream and frame-activity signal, and writes each frame into a 2 KB frame buffer from address 0.
- Runs CRC-16/MODBUS over the frame and signals rx_start, rx_done and rx_crc_rslt.
- Provides the registered read port that the downstream reader uses to fetch header and payload bytes.

---
 rtl/rx_frame_pkg.sv | 35 +++
 rtl/rx_frame_buf_if.sv | 29 ++
 rtl/rx_crc16.sv | 12 +
 rtl/rx_frame_buf.sv | 258 +++++++++++++++++++++++++
 tb/tb_rx_frame_buf.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types, constants and the CRC-16/MODBUS byte step for the receive framing stage.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_CHK  = 2'b10,
    ST_DROP = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    RSLT_NONE = 2'b00,
    RSLT_PASS = 2'b01,
    RSLT_FAIL = 2'b10,
    RSLT_LEN  = 2'b11
  } rslt_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Reflected CRC-16 over one byte, LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_frame_buf_if.sv
// PHY-side, read-port and result signals of the receive framing stage.
interface rx_frame_buf_if #(
  parameter int BUF_AW = 11
);

  logic              ini_done;
  logic              phy_frame_act;
  logic              phy_byte_en;
  logic [7:0]        phy_byte;
  logic              rx_buf_rden;
  logic [BUF_AW-1:0] rx_buf_raddr;
  logic [7:0]        rx_buf_rdata;
  logic              rx_start;
  logic              rx_done;
  logic [1:0]        rx_crc_rslt;
  logic [BUF_AW:0]   rx_len;
  logic              rx_busy;

  modport master (
    output ini_done, phy_frame_act, phy_byte_en, phy_byte, rx_buf_rden, rx_buf_raddr,
    input  rx_buf_rdata, rx_start, rx_done, rx_crc_rslt, rx_len, rx_busy
  );

  modport slave (
    input  ini_done, phy_frame_act, phy_byte_en, phy_byte, rx_buf_rden, rx_buf_raddr,
    output rx_buf_rdata, rx_start, rx_done, rx_crc_rslt, rx_len, rx_busy
  );

endinterface

// File: rtl/rx_crc16.sv
// Combinational single-byte CRC-16/MODBUS update; the running CRC lives in the caller.
module rx_crc16
  import rx_frame_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  assign o_crc = crc16_step(i_crc, i_byte);

endmodule

// File: rtl/rx_frame_buf.sv
// Receive framing stage: captures PHY frames into a byte buffer, checks CRC-16/MODBUS and length.
// Optional inter-byte idle timeout is compiled in with RX_TIMEOUT_EN.
module rx_frame_buf
  import rx_frame_pkg::*;
#(
  parameter int BUF_AW      = 11,
  parameter int MIN_LEN     = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic         clk,
  input  logic         reset,
  rx_frame_buf_if.slave bus
);

  localparam int              DEPTH     = 2 ** BUF_AW;
  localparam logic [BUF_AW:0] MIN_LEN_V = (BUF_AW + 1)'(MIN_LEN);
  localparam logic [BUF_AW:0] PTR_ONE   = (BUF_AW + 1)'(1'b1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_act_d;
  logic [BUF_AW:0]   r_ptr;
  logic [15:0]       r_crc;
  logic              r_ovf;
  logic [7:0]        r_mem [DEPTH];

  logic [7:0]        r_rdata;
  logic              r_start;
  logic              r_done;
  logic              r_busy;
  rslt_t             r_rslt;
  logic [BUF_AW:0]   r_len;

  logic              w_start_nxt;
  logic              w_done_nxt;
  logic              w_busy_nxt;
  rslt_t             w_rslt_nxt;
  logic [BUF_AW:0]   w_len_nxt;

  logic              w_accept;
  logic              w_go_recv;
  logic              w_ptr_full;
  logic              w_wr_en;
  logic [BUF_AW-1:0] w_wr_addr;
  logic [15:0]       w_crc_in;
  logic [15:0]       w_crc_step;
  logic              w_tmo_hit;
  logic              w_tmo_flag;

  assign w_accept   = bus.phy_frame_act & bus.phy_byte_en;
  // r_act_d resets high so a frame already in flight at reset release is not seen as a start.
  assign w_go_recv  = (r_state == ST_IDLE) & bus.phy_frame_act & bus.ini_done & ~r_act_d;
  assign w_ptr_full = r_ptr[BUF_AW];
  assign w_wr_en    = w_accept & (w_go_recv | ((r_state == ST_RECV) & ~w_ptr_full));
  assign w_wr_addr  = w_go_recv ? {BUF_AW{1'b0}} : r_ptr[BUF_AW-1:0];
  assign w_crc_in   = w_go_recv ? CRC_INIT : r_crc;

  rx_crc16 u_crc (
    .i_crc  (w_crc_in),
    .i_byte (bus.phy_byte),
    .o_crc  (w_crc_step)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_idle_cnt;
  logic             r_tmo;

  assign w_tmo_hit  = (r_state == ST_RECV) & bus.phy_frame_act & ~w_accept &
                      (r_idle_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_tmo_flag = r_tmo;

  // Idle cycles since the last accepted byte while receiving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= {TMO_W{1'b0}};
    end else if ((r_state == ST_RECV) && !w_accept) begin
      r_idle_cnt <= r_idle_cnt + TMO_W'(1'b1);
    end else begin
      r_idle_cnt <= {TMO_W{1'b0}};
    end
  end

  // Remembers that the current frame was closed by the idle limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= 1'b0;
    end else if (w_go_recv) begin
      r_tmo <= 1'b0;
    end else if (w_tmo_hit) begin
      r_tmo <= 1'b1;
    end else begin
      r_tmo <= r_tmo;
    end
  end
`else
  logic w_unused_tmo;

  assign w_tmo_hit    = 1'b0;
  assign w_tmo_flag   = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYC != 32'sd0);
`endif

  // FSM state register and frame-activity edge register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_act_d <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_act_d <= bus.phy_frame_act;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.phy_frame_act) begin
          if (bus.ini_done && !r_act_d) begin
            w_state_nxt = ST_RECV;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (!bus.phy_frame_act || w_tmo_hit) begin
          w_state_nxt = ST_CHK;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_CHK: begin
        if (w_tmo_flag) begin
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!bus.phy_frame_act) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output decode; results are computed in CHK from the settled count and CRC residue.
  always_comb begin
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_rslt_nxt  = r_rslt;
    w_len_nxt   = r_len;
    w_busy_nxt  = (w_state_nxt == ST_RECV) || (w_state_nxt == ST_CHK);
    case (r_state)
      ST_IDLE: begin
        if (w_go_recv) begin
          w_start_nxt = 1'b1;
          w_rslt_nxt  = RSLT_NONE;
        end else begin
          w_start_nxt = 1'b0;
        end
      end
      ST_CHK: begin
        w_done_nxt = 1'b1;
        w_len_nxt  = r_ptr;
        if (w_tmo_flag || r_ovf || (r_ptr < MIN_LEN_V)) begin
          w_rslt_nxt = RSLT_LEN;
        end else if (r_crc == 16'h0000) begin
          w_rslt_nxt = RSLT_PASS;
        end else begin
          w_rslt_nxt = RSLT_FAIL;
        end
      end
      default: begin
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_rslt  <= RSLT_NONE;
      r_len   <= {(BUF_AW + 1){1'b0}};
    end else begin
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_rslt  <= w_rslt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Write pointer, running CRC and overflow; the pointer saturates at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= {(BUF_AW + 1){1'b0}};
      r_crc <= CRC_INIT;
      r_ovf <= 1'b0;
    end else if (w_go_recv) begin
      r_ptr <= w_wr_en ? PTR_ONE : {(BUF_AW + 1){1'b0}};
      r_crc <= w_wr_en ? w_crc_step : CRC_INIT;
      r_ovf <= 1'b0;
    end else if (w_wr_en) begin
      r_ptr <= r_ptr + PTR_ONE;
      r_crc <= w_crc_step;
      r_ovf <= r_ovf;
    end else if ((r_state == ST_RECV) && w_accept && w_ptr_full) begin
      r_ptr <= r_ptr;
      r_crc <= r_crc;
      r_ovf <= 1'b1;
    end else begin
      r_ptr <= r_ptr;
      r_crc <= r_crc;
      r_ovf <= r_ovf;
    end
  end

  // Frame buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= bus.phy_byte;
    end
  end

  // Registered read-first read port; holds its value when not enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 8'h00;
    end else if (bus.rx_buf_rden) begin
      r_rdata <= r_mem[bus.rx_buf_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign bus.rx_buf_rdata = r_rdata;
  assign bus.rx_start     = r_start;
  assign bus.rx_done      = r_done;
  assign bus.rx_crc_rslt  = r_rslt;
  assign bus.rx_len       = r_len;
  assign bus.rx_busy      = r_busy;

endmodule

// File: tb/tb_rx_frame_buf.sv
// Self-checking bench for rx_frame_buf: frame table, result scoreboard, buffer model readback.
module tb_rx_frame_buf;
  import rx_frame_pkg::*;

  localparam int AW = 11;
`ifdef RX_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  typedef struct {
    logic [1:0]  rslt;
    logic [AW:0] len;
  } exp_t;

  typedef struct {
    logic [7:0] d [8];
    int         n;
    bit         tail;
    bit         gap;
    logic [1:0] rslt;
    int         len;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_frame_buf_if #(.BUF_AW(AW)) bus ();

  rx_frame_buf #(.BUF_AW(AW), .MIN_LEN(5), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t       exp_q[$];
  vec_t       vecs[6];
  logic [7:0] fbuf [2049];
  logic [7:0] mem_model [2048];
  int         n_cmp = 0;
  int         n_err = 0;
  int         start_cnt = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_bytes(input logic [7:0] d [8], input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, d[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Result scoreboard: every rx_done pops one expected frame result.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rx_start === 1'b1) start_cnt++;
    if (bus.rx_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", int'(bus.rx_done), 0);
      end else begin
        e = exp_q.pop_front();
        chk("rx_crc_rslt", int'(bus.rx_crc_rslt), int'(e.rslt));
        chk("rx_len", int'(bus.rx_len), int'(e.len));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input bit tail, input bit gap, input bit exp_start);
    @(negedge clk);
    bus.phy_frame_act = 1'b1;
    bus.phy_byte_en   = 1'b1;
    bus.phy_byte      = fbuf[0];
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (i == 1) chk("rx_start_latency", int'(bus.rx_start), int'(exp_start));
      if (i == 2) chk("rx_busy_in_frame", int'(bus.rx_busy), int'(exp_start));
      if (gap) begin
        bus.phy_byte_en = 1'b0;
        @(negedge clk);
      end
      bus.phy_byte_en = 1'b1;
      bus.phy_byte    = fbuf[i];
    end
    @(negedge clk);
    bus.phy_frame_act = 1'b0;
    bus.phy_byte_en   = tail;
    bus.phy_byte      = 8'hE7;
  endtask

  task automatic wait_done();
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      bus.phy_byte_en = 1'b0;
      cyc++;
      if (bus.rx_done === 1'b1) seen = 1'b1;
    end
    chk("rx_done_latency", seen ? cyc : -1, 2);
  endtask

  task automatic run_frame(input int n, input bit tail, input bit gap, input logic [1:0] rslt, input int len);
    exp_t e;
    e.rslt = rslt;
    e.len  = (AW + 1)'(len);
    exp_q.push_back(e);
    send_frame(n, tail, gap, 1'b1);
    wait_done();
    for (int i = 0; i < n && i < 2048; i++) mem_model[i] = fbuf[i];
  endtask

  task automatic rd_check(input int addr, input string name);
    @(negedge clk);
    bus.rx_buf_rden  = 1'b1;
    bus.rx_buf_raddr = AW'(addr);
    @(negedge clk);
    bus.rx_buf_rden  = 1'b0;
    chk(name, int'(bus.rx_buf_rdata), int'(mem_model[addr]));
  endtask

  initial begin
    int s0;
    int d0;
    int last_addr;
    logic [15:0] c;

    reset             = 1'b0;
    bus.ini_done      = 1'b1;
    bus.phy_frame_act = 1'b0;
    bus.phy_byte_en   = 1'b0;
    bus.phy_byte      = 8'h00;
    bus.rx_buf_rden   = 1'b0;
    bus.rx_buf_raddr  = '0;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("reset_rdata", int'(bus.rx_buf_rdata), 0);
    chk("reset_start", int'(bus.rx_start), 0);
    chk("reset_done", int'(bus.rx_done), 0);
    chk("reset_rslt", int'(bus.rx_crc_rslt), 0);
    chk("reset_len", int'(bus.rx_len), 0);
    chk("reset_busy", int'(bus.rx_busy), 0);

    vecs[0] = '{d: '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A}, n: 8, tail: 1'b0, gap: 1'b0, rslt: RSLT_PASS, len: 8};
    vecs[1] = '{d: '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B}, n: 8, tail: 1'b0, gap: 1'b0, rslt: RSLT_FAIL, len: 8};
    vecs[2] = '{d: '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, tail: 1'b0, gap: 1'b0, rslt: RSLT_LEN, len: 3};
    vecs[3] = '{d: '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A}, n: 8, tail: 1'b1, gap: 1'b1, rslt: RSLT_PASS, len: 8};
    vecs[4] = '{d: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4, tail: 1'b0, gap: 1'b0, rslt: RSLT_LEN, len: 4};
    vecs[5] = '{d: '{8'h5A, 8'hC3, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 5, tail: 1'b1, gap: 1'b0, rslt: RSLT_PASS, len: 5};
    c = crc_bytes(vecs[5].d, 3);
    vecs[5].d[3] = c[7:0];
    vecs[5].d[4] = c[15:8];

    last_addr = 0;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) fbuf[i] = vecs[v].d[i];
      run_frame(vecs[v].n, vecs[v].tail, vecs[v].gap, vecs[v].rslt, vecs[v].len);
      for (int a = 0; a < vecs[v].n; a++) rd_check(a, "rdata_frame");
      last_addr = vecs[v].n - 1;
    end

    @(negedge clk);
    bus.rx_buf_raddr = '0;
    tick(2);
    chk("rdata_hold", int'(bus.rx_buf_rdata), int'(mem_model[last_addr]));

    // Oversized frame: 2049th byte must neither be stored nor wrap onto address 0.
    for (int i = 0; i < 2048; i++) fbuf[i] = 8'(i * 3 + 1);
    fbuf[2048] = 8'hEE;
    run_frame(2049, 1'b0, 1'b0, RSLT_LEN, 2048);
    rd_check(0, "rdata_ovf_addr0");
    rd_check(1, "rdata_ovf_addr1");
    rd_check(2047, "rdata_ovf_last");

    // Frame while card is not initialised is discarded.
    bus.ini_done = 1'b0;
    for (int i = 0; i < 8; i++) fbuf[i] = 8'h90 + 8'(i);
    tick(2);
    s0 = start_cnt;
    d0 = done_cnt;
    send_frame(8, 1'b0, 1'b0, 1'b0);
    tick(5);
    chk("noinit_start", start_cnt - s0, 0);
    chk("noinit_done", done_cnt - d0, 0);
    rd_check(0, "noinit_buf0");
    rd_check(5, "noinit_buf5");
    bus.ini_done = 1'b1;

    // Reset mid-frame, released with the frame still active.
    for (int i = 0; i < 8; i++) fbuf[i] = vecs[0].d[i];
    tick(2);
    s0 = start_cnt;
    d0 = done_cnt;
    @(negedge clk);
    bus.phy_frame_act = 1'b1;
    bus.phy_byte_en   = 1'b1;
    bus.phy_byte      = fbuf[0];
    @(negedge clk);
    bus.phy_byte      = fbuf[1];
    @(negedge clk);
    reset           = 1'b0;
    bus.phy_byte_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      bus.phy_byte_en = 1'b1;
      bus.phy_byte    = fbuf[i];
    end
    @(negedge clk);
    bus.phy_frame_act = 1'b0;
    bus.phy_byte_en   = 1'b0;
    tick(4);
    chk("rstmid_start", start_cnt - s0, 1);
    chk("rstmid_done", done_cnt - d0, 0);
    chk("rstmid_len", int'(bus.rx_len), 0);
    chk("rstmid_rslt", int'(bus.rx_crc_rslt), 0);
    chk("rstmid_busy", int'(bus.rx_busy), 0);
    mem_model[0] = fbuf[0];
    mem_model[1] = fbuf[1];
    rd_check(1, "rstmid_buf1");
    rd_check(2, "rstmid_buf2");

    run_frame(8, 1'b0, 1'b0, RSLT_PASS, 8);
    for (int a = 0; a < 8; a++) rd_check(a, "rdata_after_rst");

`ifdef RX_TIMEOUT_EN
    // Idle gap beyond the limit closes the frame early; the rest is dropped.
    begin
      exp_t e;
      for (int i = 0; i < 8; i++) fbuf[i] = 8'hC0 + 8'(i);
      e.rslt = RSLT_LEN;
      e.len  = (AW + 1)'(3);
      exp_q.push_back(e);
      tick(2);
      s0 = start_cnt;
      d0 = done_cnt;
      @(negedge clk);
      bus.phy_frame_act = 1'b1;
      bus.phy_byte_en   = 1'b1;
      bus.phy_byte      = fbuf[0];
      for (int i = 1; i < 3; i++) begin
        @(negedge clk);
        bus.phy_byte = fbuf[i];
      end
      @(negedge clk);
      bus.phy_byte_en = 1'b0;
      tick(20);
      chk("tmo_done_in_gap", done_cnt - d0, 1);
      for (int i = 3; i < 8; i++) begin
        bus.phy_byte_en = 1'b1;
        bus.phy_byte    = fbuf[i];
        @(negedge clk);
      end
      bus.phy_frame_act = 1'b0;
      bus.phy_byte_en   = 1'b0;
      tick(5);
      chk("tmo_start", start_cnt - s0, 1);
      chk("tmo_done", done_cnt - d0, 1);
      for (int i = 0; i < 3; i++) mem_model[i] = fbuf[i];
      rd_check(2, "tmo_buf2");
      rd_check(3, "tmo_buf3");
      for (int i = 0; i < 8; i++) fbuf[i] = vecs[0].d[i];
      run_frame(8, 1'b0, 1'b0, RSLT_PASS, 8);
    end
`endif

    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
